// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the parametrised instruction sequence controller.
package seq_gen_pkg;

    typedef enum logic [2:0] {
        PH_FETCH   = 3'd0,
        PH_DECODE  = 3'd1,
        PH_EXECUTE = 3'd2,
        PH_WAIT    = 3'd3,
        PH_UPDATE  = 3'd4,
        PH_HALT    = 3'd5
    } phase_t;

    localparam int unsigned OP_LOAD   = 32'd0;
    localparam int unsigned OP_STORE  = 32'd1;
    localparam int unsigned OP_ALU_LO = 32'd2;
    localparam int unsigned OP_ALU_HI = 32'd7;
    localparam int unsigned OP_B      = 32'd8;
    localparam int unsigned OP_BZ     = 32'd9;
    localparam int unsigned OP_BN     = 32'd10;
    localparam int unsigned OP_BV     = 32'd11;
    localparam int unsigned OP_BC     = 32'd12;
    localparam int unsigned OP_NOP    = 32'd13;
    localparam int unsigned OP_HALT   = 32'd14;

    localparam int CTRL_W  = 32'sd13;
    localparam int IR_EN   = 32'sd0;
    localparam int A_EN    = 32'sd1;
    localparam int B_EN    = 32'sd2;
    localparam int PDR_EN  = 32'sd3;
    localparam int PORT_EN = 32'sd4;
    localparam int PORT_RD = 32'sd5;
    localparam int PC_EN   = 32'sd6;
    localparam int PC_LOAD = 32'sd7;
    localparam int ALU_EN  = 32'sd8;
    localparam int ALU_OE  = 32'sd9;
    localparam int RAM_OE  = 32'sd10;
    localparam int RDR_EN  = 32'sd11;
    localparam int RAM_CS  = 32'sd12;

    // Flags are {C,V,N,Z}; only the conditional branches inspect them.
    function automatic logic branch_taken(input int unsigned op, input logic [3:0] flags);
        logic taken;
        case (op)
            OP_B:    taken = 1'b1;
            OP_BZ:   taken = flags[0];
            OP_BN:   taken = flags[1];
            OP_BV:   taken = flags[2];
            OP_BC:   taken = flags[3];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational map from the phase being entered plus instruction context to datapath enables.
module seq_ctrl_decode
    import seq_gen_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32'd7,
    parameter int unsigned OP_W    = 32'd4,
    parameter int unsigned IO_BASE = 32'd64
) (
    input  phase_t              phase_i,
    input  logic [OP_W-1:0]     op_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [3:0]          flags_i,
    output logic [CTRL_W-1:0]   ctrl_o
);

    int unsigned       op_u;
    int unsigned       addr_u;
    logic [CTRL_W-1:0] dec_s;
    logic [CTRL_W-1:0] exe_s;

    // Per-phase enable selection; WAIT deliberately reuses the EXECUTE pattern.
    always_comb begin
        op_u   = 32'(op_i);
        addr_u = 32'(addr_i);
        dec_s  = '0;
        exe_s  = '0;
        ctrl_o = '0;

        if (op_u == OP_LOAD) begin
            if (addr_u < IO_BASE) begin
                dec_s[RAM_CS] = 1'b1;
                dec_s[RAM_OE] = 1'b1;
                dec_s[RDR_EN] = 1'b1;
                exe_s = dec_s;
            end else if (addr_u == IO_BASE) begin
                exe_s[A_EN] = 1'b1;
            end else if (addr_u == IO_BASE + 32'd1) begin
                exe_s[B_EN] = 1'b1;
            end else if (addr_u == IO_BASE + 32'd2) begin
                exe_s[PDR_EN] = 1'b1;
            end else if (addr_u == IO_BASE + 32'd3) begin
                exe_s[PORT_EN] = 1'b1;
            end else begin
                exe_s = '0;
            end
        end else if (op_u == OP_STORE) begin
            if (addr_u == IO_BASE + 32'd3) begin
                dec_s[PORT_RD] = 1'b1;
            end else begin
                dec_s[ALU_OE] = 1'b1;
            end
            exe_s[ALU_OE] = 1'b1;
            exe_s[RAM_CS] = (addr_u < IO_BASE);
        end else if (op_u >= OP_ALU_LO && op_u <= OP_ALU_HI) begin
            dec_s[A_EN]   = 1'b1;
            dec_s[B_EN]   = 1'b1;
            exe_s[ALU_EN] = 1'b1;
        end else begin
            dec_s = '0;
        end

        case (phase_i)
            PH_FETCH: begin
                ctrl_o[IR_EN]  = 1'b1;
                ctrl_o[RAM_CS] = 1'b1;
                ctrl_o[RAM_OE] = 1'b1;
            end
            PH_DECODE:  ctrl_o = dec_s;
            PH_EXECUTE: ctrl_o = exe_s;
            PH_WAIT:    ctrl_o = exe_s;
            PH_UPDATE: begin
                if (branch_taken(op_u, flags_i)) begin
                    ctrl_o[PC_LOAD] = 1'b1;
                end else begin
                    ctrl_o[PC_EN] = 1'b1;
                end
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_ctrl_gen.sv
// Instruction sequence controller: phase FSM, operand/flag latches, memory wait timeout, registered enables.
module seq_ctrl_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32'd7,
    parameter int unsigned OP_W     = 32'd4,
    parameter int unsigned IO_BASE  = 32'd64,
    parameter int unsigned MEM_WAIT = 32'd1,
    parameter int unsigned WAIT_MAX = 32'd8
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                EN,
    input  logic [OP_W-1:0]     OPCODE,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [3:0]          FLAGS,
    input  logic                MEM_RDY,
    output phase_t              PHASE,
    output logic [CTRL_W-1:0]   CTRL,
    output logic                HALTED,
    output logic                ILLEGAL,
    output logic                TIMEOUT
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 32'd1);

    phase_t              phase_q, phase_d;
    logic                primed_q, primed_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          flags_q, flags_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    logic [CTRL_W-1:0]   dec_ctrl_s;
    logic                mem_acc_s;
    logic                expire_s;
    int unsigned         op_u;
    int unsigned         addr_u;

    // State and output registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            phase_q   <= PH_FETCH;
            primed_q  <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            flags_q   <= 4'd0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            primed_q  <= primed_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next phase and latches; the first enabled edge after reset only primes FETCH enables.
    always_comb begin
        op_u      = 32'(op_q);
        addr_u    = 32'(addr_q);
        mem_acc_s = (MEM_WAIT != 32'd0) && (op_u == OP_LOAD || op_u == OP_STORE)
                    && (addr_u < IO_BASE);
        expire_s  = (cnt_q == CNT_W'(WAIT_MAX - 32'd1));
        phase_d   = phase_q;
        primed_d  = primed_q;
        op_d      = op_q;
        addr_d    = addr_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        if (EN) begin
            case (phase_q)
                PH_FETCH: begin
                    if (primed_q) begin
                        phase_d = PH_DECODE;
                        op_d    = OPCODE;
                        addr_d  = ADDR;
                    end else begin
                        primed_d = 1'b1;
                    end
                end
                PH_DECODE: begin
                    if (op_u == OP_HALT) begin
                        phase_d = PH_HALT;
                    end else begin
                        phase_d   = PH_EXECUTE;
                        illegal_d = (op_u > OP_HALT);
                    end
                end
                PH_EXECUTE: begin
                    if (mem_acc_s) begin
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        phase_d = PH_UPDATE;
                        flags_d = FLAGS;
                    end
                end
                PH_WAIT: begin
                    if (MEM_RDY || expire_s) begin
                        phase_d   = PH_UPDATE;
                        flags_d   = FLAGS;
                        timeout_d = !MEM_RDY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_UPDATE: phase_d = PH_FETCH;
                PH_HALT:   phase_d = PH_HALT;
                default:   phase_d = PH_FETCH;
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // Enables are computed for the phase being entered so CTRL and PHASE move together.
    always_comb begin
        if (EN) begin
            ctrl_d   = dec_ctrl_s;
            halted_d = (phase_d == PH_HALT);
        end else begin
            ctrl_d   = ctrl_q;
            halted_d = halted_q;
        end
    end

    seq_ctrl_decode #(
        .ADDR_W  (ADDR_W),
        .OP_W    (OP_W),
        .IO_BASE (IO_BASE)
    ) u_decode (
        .phase_i (phase_d),
        .op_i    (op_d),
        .addr_i  (addr_d),
        .flags_i (flags_d),
        .ctrl_o  (dec_ctrl_s)
    );

    assign PHASE   = phase_q;
    assign CTRL    = ctrl_q;
    assign HALTED  = halted_q;
    assign ILLEGAL = illegal_q;
    assign TIMEOUT = timeout_q;

endmodule
